// File: rtl/sort_seq_pkg.sv
// sort_seq shared defs: array geometry, word types
// and the gray-coded sequencer state enum.
package sort_seq_pkg;
  localparam int NUM_ROWS = 8;
  localparam int ADDR_W = $clog2(NUM_ROWS);

  typedef logic [ADDR_W-1:0] t_addr;
  typedef logic [7:0] t_data;

  // Gray order LOAD->KICK->SORT->DRAIN->LOAD
  typedef enum logic [1:0] {
    LOAD  = 2'b00,
    KICK  = 2'b01,
    SORT  = 2'b11,
    DRAIN = 2'b10
  } t_seq_fsm;
endpackage

// File: rtl/sort_seq_if.sv
// Host stream bundle: word input (in_*) and sorted
// word output (out_*), both valid/ready.
interface sort_seq_if;
  import sort_seq_pkg::*;

  logic  in_valid;
  logic  in_ready;
  t_data in_data;
  logic  out_valid;
  logic  out_ready;
  t_data out_data;
  logic  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sort_seq_mem_port_mux.sv
// Array port select: sequencer owns it in LOAD/DRAIN,
// engine owns it in SORT. en=0 blocks all writes.
module sort_seq_mem_port_mux
  import sort_seq_pkg::*;
(
  input  t_seq_fsm state,
  input  logic     en,
  input  t_addr    cnt,
  input  logic     in_valid,
  input  t_data    in_data,
  input  t_addr    eng_rd_addr,
  input  logic     eng_wr_en,
  input  t_addr    eng_wr_addr,
  input  t_data    eng_wr_data,
  output t_addr    mem_rd_addr,
  output logic     mem_wr_en,
  output t_addr    mem_wr_addr,
  output t_data    mem_wr_data
);
  always_comb begin
    mem_rd_addr = cnt;
    mem_wr_en   = 1'b0;
    mem_wr_addr = cnt;
    mem_wr_data = in_data;
    unique case (1'b1)
      (state == LOAD): begin
        mem_wr_en = en & in_valid;
      end
      (state == SORT): begin
        mem_rd_addr = eng_rd_addr;
        mem_wr_en   = en & eng_wr_en;
        mem_wr_addr = eng_wr_addr;
        mem_wr_data = eng_wr_data;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/sort_seq.sv
// Sort job sequencer: load NUM_ROWS words, kick the
// engine, lend it the array, then drain sorted words.
module sort_seq
  import sort_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  sort_seq_if.slave    host,
  output logic         busy,
  output logic         eng_start,
  input  logic         eng_done,
  input  t_addr        eng_rd_addr,
  output t_data        eng_rd_data,
  input  logic         eng_wr_en,
  input  t_addr        eng_wr_addr,
  input  t_data        eng_wr_data,
  output t_addr        mem_rd_addr,
  input  t_data        mem_rd_data,
  output logic         mem_wr_en,
  output t_addr        mem_wr_addr,
  output t_data        mem_wr_data
);
  t_seq_fsm state_q, state_d;
  t_addr    cnt_q, cnt_d;
  logic     last;
  logic     in_ready;
  logic     out_valid;

  assign last = (cnt_q == t_addr'(NUM_ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are masked by rst so the reset cycle
  // is quiet no matter which state we were in.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    eng_start = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = ~rst;
        if (host.in_valid) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (last) state_d = KICK;
        end
      end
      KICK: begin
        eng_start = ~rst;
        state_d   = SORT;
      end
      SORT: begin
        if (eng_done) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        out_valid = ~rst;
        if (host.out_ready) begin
          cnt_d = last ? '0 : cnt_q + 1'b1;
          if (last) state_d = LOAD;
        end
      end
      default: ;
    endcase
  end

  assign host.in_ready  = in_ready;
  assign host.out_valid = out_valid;
  assign host.out_data  = mem_rd_data;
  assign host.out_last  = out_valid & last;
  assign busy           = (state_q != LOAD) & ~rst;
  assign eng_rd_data    = mem_rd_data;

  sort_seq_mem_port_mux u_mux (
    .state       (state_q),
    .en          (~rst),
    .cnt         (cnt_q),
    .in_valid    (host.in_valid),
    .in_data     (host.in_data),
    .eng_rd_addr (eng_rd_addr),
    .eng_wr_en   (eng_wr_en),
    .eng_wr_addr (eng_wr_addr),
    .eng_wr_data (eng_wr_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );
endmodule

// File: tb/tb_sort_seq.sv
// sort_seq bench: behavioural engine + array, sorted
// reference, directed and randomized jobs.
module tb_sort_seq;
  import sort_seq_pkg::*;

  typedef t_data t_row [NUM_ROWS];

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  busy, eng_start, eng_done;
  t_addr eng_rd_addr, eng_wr_addr;
  t_data eng_rd_data, eng_wr_data;
  logic  eng_wr_en;
  t_addr mem_rd_addr, mem_wr_addr;
  t_data mem_rd_data, mem_wr_data;
  logic  mem_wr_en;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int kicks  = 0;
  int bad_wr = 0;
  logic done_last = 1'b0;

  sort_seq_if bus();

  sort_seq dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bus),
    .busy        (busy),
    .eng_start   (eng_start),
    .eng_done    (eng_done),
    .eng_rd_addr (eng_rd_addr),
    .eng_rd_data (eng_rd_data),
    .eng_wr_en   (eng_wr_en),
    .eng_wr_addr (eng_wr_addr),
    .eng_wr_data (eng_wr_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic t_row sort8(input t_row a);
    t_row r = a;
    t_data t;
    for (int i = 0; i < NUM_ROWS; i++)
      for (int j = 0; j < NUM_ROWS - 1 - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  // Array: combinational read, clocked write.
  t_data mem [NUM_ROWS];
  assign mem_rd_data = mem[mem_rd_addr];

  // Engine model: read all, sort, write back, done.
  // When idle it drives junk that must be ignored.
  int   e_st = 0;
  int   ek = 0;
  t_row eb, es;

  always @(posedge clk) begin
    if (rst) begin
      e_st <= 0; ek <= 0;
      eng_wr_en <= 1'b0; eng_done <= 1'b0;
      eng_rd_addr <= '0; eng_wr_addr <= '0;
      eng_wr_data <= '0;
    end else begin
      case (e_st)
        0: begin
          eng_wr_en   <= 1'($urandom_range(0, 1));
          eng_wr_addr <= t_addr'($urandom);
          eng_wr_data <= t_data'($urandom);
          eng_rd_addr <= t_addr'($urandom);
          eng_done    <= ($urandom_range(0, 3) == 0);
          if (eng_start) begin
            e_st <= 1; ek <= 0;
            eng_rd_addr <= '0;
            eng_wr_en <= 1'b0;
            eng_done <= 1'b0;
          end
        end
        1: begin
          eb[ek] <= eng_rd_data;
          if (ek == NUM_ROWS - 1) begin
            e_st <= 4;
          end else begin
            ek <= ek + 1;
            eng_rd_addr <= t_addr'(ek + 1);
          end
        end
        4: begin
          es <= sort8(eb);
          ek <= 0;
          e_st <= 2;
        end
        2: begin
          if (ek == NUM_ROWS) begin
            eng_wr_en <= 1'b0;
            eng_done <= 1'b1;
            e_st <= 3;
          end else begin
            eng_wr_en <= 1'b1;
            eng_wr_addr <= t_addr'(ek);
            eng_wr_data <= es[ek];
            ek <= ek + 1;
          end
        end
        default: begin
          eng_done <= 1'b0;
          e_st <= 0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_wr_en && (rst ||
        !((bus.in_valid && bus.in_ready) ||
          (e_st == 2 && eng_wr_en))))
      bad_wr <= bad_wr + 1;
    if (eng_start) starts <= starts + 1;
    done_last <= (e_st == 3) && !rst;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // gap: 0 back-to-back, 1 every other, 2 random
  task automatic load(input t_row d, input int gap,
                      input logic hold);
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (gap == 1 ||
          (gap == 2 && $urandom_range(0, 1) == 1)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("idle_wr", mem_wr_en, 0);
        chk("idle_rdy", bus.in_ready, 1);
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = d[i];
      #1;
      chk("in_ready", bus.in_ready, 1);
      chk("busy_load", busy, 0);
      chk("load_we", mem_wr_en, 1);
      chk("load_addr", mem_wr_addr, i);
    end
    @(negedge clk);
    bus.in_valid = hold;
    bus.in_data = t_data'($urandom);
    #1;
    kicks++;
    chk("kick_start", eng_start, 1);
    chk("kick_rdy", bus.in_ready, 0);
    chk("kick_busy", busy, 1);
  endtask

  task automatic drain(input t_row exp, input int sidx,
                       input int slen, input logic hold,
                       input logic rnd);
    int n = 0;
    int st = 0;
    int t = 0;
    while (n < NUM_ROWS && t < 200) begin
      @(negedge clk);
      t++;
      bus.in_valid = hold;
      bus.in_data = t_data'($urandom);
      if (n == sidx && st < slen)
        bus.out_ready = 1'b0;
      else
        bus.out_ready =
          rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("job_rdy", bus.in_ready, 0);
      chk("job_start", eng_start, 0);
      chk("job_busy", busy, 1);
      if (done_last) chk("first_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, exp[n]);
        chk("out_last", bus.out_last, n == NUM_ROWS - 1);
        chk("eng_rd", eng_rd_data, mem_rd_data);
        if (bus.out_ready) n++;
        else if (n == sidx) st++;
      end
    end
    chk("drain_words", n, NUM_ROWS);
    bus.out_ready = 1'b1;
  endtask

  task automatic run_job(input t_row d, input int gap,
                         input int sidx, input int slen,
                         input logic hold,
                         input logic rnd);
    load(d, gap, hold);
    drain(sort8(d), sidx, slen, hold, rnd);
  endtask

  initial begin
    t_row d1, dq, dd, dr;
    d1 = '{8'd5, 8'd3, 8'd7, 8'd1,
           8'd8, 8'd2, 8'd6, 8'd4};
    dq = '{default: 8'd4};
    dd = '{8'd8, 8'd7, 8'd6, 8'd5,
           8'd4, 8'd3, 8'd2, 8'd1};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    #1;
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_we", mem_wr_en, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", bus.in_ready, 1);

    run_job(d1, 0, -1, 0, 1'b0, 1'b0);
    run_job(d1, 1, -1, 0, 1'b0, 1'b0);
    run_job(d1, 0, 1, 3, 1'b0, 1'b0);
    run_job(dq, 0, -1, 0, 1'b0, 1'b0);
    run_job(dd, 0, -1, 0, 1'b0, 1'b0);
    run_job(d1, 0, -1, 0, 1'b1, 1'b0);

    for (int i = 0; i < NUM_ROWS; i++)
      dr[i] = t_data'($urandom);
    load(dr, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", bus.in_ready, 0);
    chk("mid_rst_ov", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", eng_start, 0);
    chk("mid_rst_we", mem_wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_busy", busy, 0);
    chk("after_rst_rdy", bus.in_ready, 1);
    chk("after_rst_ov", bus.out_valid, 0);

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NUM_ROWS; i++)
        dr[i] = t_data'($urandom);
      run_job(dr, 2, -1, 0,
              1'($urandom_range(0, 1)), 1'b1);
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("start_pulses", starts, kicks);
    chk("bad_writes", bad_wr, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
